alu_op_sequencer: RTL

ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

---
 rtl/alu_op_sequencer_pkg.sv | 46 ++++
 rtl/alu_op_sequencer_operand_regfile.sv | 32 +++
 rtl/alu_op_sequencer.sv | 118 +++++++++++
 3 files changed

// File: rtl/alu_op_sequencer_pkg.sv
// Shared types and constants for the ALU operation sequencer: FSM states,
// command kinds, register-file geometry and the external ALU function codes.
package alu_op_sequencer_pkg;

  localparam int DATA_W = 16;
  localparam int REG_N  = 4;
  localparam int ADDR_W = 2;
  localparam int FN_W   = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic KIND_ALU  = 1'b0;
  localparam logic KIND_LOAD = 1'b1;

  typedef enum logic [FN_W-1:0] {
    FN_ADD      = 4'd0,
    FN_SUB_XY   = 4'd1,
    FN_SUB_YX   = 4'd2,
    FN_ZERO     = 4'd3,
    FN_ONE      = 4'd4,
    FN_MINUS1   = 4'd5,
    FN_NEG_X    = 4'd6,
    FN_NEG_Y    = 4'd7,
    FN_NOT_X    = 4'd8,
    FN_NOT_Y    = 4'd9,
    FN_INC_X    = 4'd10,
    FN_INC_Y    = 4'd11,
    FN_DEC_X    = 4'd12,
    FN_DEC_Y    = 4'd13,
    FN_AND      = 4'd14,
    FN_OR       = 4'd15
  } alu_fn_t;

  function automatic logic flag_zero(input logic [DATA_W-1:0] v);
    return (v == '0);
  endfunction

  function automatic logic flag_neg(input logic [DATA_W-1:0] v);
    return v[DATA_W-1];
  endfunction

endpackage

// File: rtl/alu_op_sequencer_operand_regfile.sv
// 4x16 operand register file: two combinational read ports, one synchronous
// write port, synchronous reset clearing every entry.
module operand_regfile
  import alu_op_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [1:0]  waddr,
  input  logic [15:0] wdata,
  input  logic [1:0]  raddr_a,
  input  logic [1:0]  raddr_b,
  output logic [15:0] rdata_a,
  output logic [15:0] rdata_b
);

  logic [DATA_W-1:0] regs [REG_N];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REG_N; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdata_a = regs[raddr_a];
  assign rdata_b = regs[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
// Command sequencer that drives an external combinational ALU from a small
// register file and returns each result through a valid/ready handshake.
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_kind,
  input  logic [3:0]  cmd_fn,
  input  logic [1:0]  cmd_dst,
  input  logic [1:0]  cmd_srca,
  input  logic [1:0]  cmd_srcb,
  input  logic [15:0] cmd_imm,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [3:0]  alu_sel,
  input  logic [15:0] alu_y,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_data,
  output logic        res_zero,
  output logic        res_neg
);

  state_t              state;
  logic [ADDR_W-1:0]   dst_exec;
  logic                rf_we;
  logic [ADDR_W-1:0]   rf_waddr;
  logic [DATA_W-1:0]   rf_wdata;
  logic [DATA_W-1:0]   rd_a;
  logic [DATA_W-1:0]   rd_b;

  operand_regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (cmd_srca),
    .raddr_b (cmd_srcb),
    .rdata_a (rd_a),
    .rdata_b (rd_b)
  );

  // The register write happens at the same edge the FSM leaves IDLE (LOAD)
  // or EXEC (ALU); the regfile's own reset wins, so an aborted op never lands.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = cmd_dst;
    rf_wdata = cmd_imm;
    case (state)
      ST_IDLE: rf_we = cmd_valid && (cmd_kind == KIND_LOAD);
      ST_EXEC: begin
        rf_we    = 1'b1;
        rf_waddr = dst_exec;
        rf_wdata = alu_y;
      end
      default: rf_we = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      res_valid <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= FN_ZERO;
      res_data  <= '0;
      dst_exec  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            if (cmd_kind == KIND_LOAD) begin
              res_data  <= cmd_imm;
              res_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              // Operands are captured before any write, so dst may alias a source.
              alu_a    <= rd_a;
              alu_b    <= rd_b;
              alu_sel  <= cmd_fn;
              dst_exec <= cmd_dst;
              state    <= ST_EXEC;
            end
          end
        end
        ST_EXEC: begin
          res_data  <= alu_y;
          res_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          res_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Flags follow the held result, never the live ALU output.
  assign res_zero = flag_zero(res_data);
  assign res_neg  = flag_neg(res_data);

endmodule
